id_ex_stage: RTL

ID/EX pipeline boundary of the 5-stage RV32I core. Registers the decoded control word plus operands produced in decode and hands them to execute. Detects load-use hazards against the instruction already in EX and inserts one bubble while holding fetch/decode. Applies branch/jump flushes and downstream freezes, and keeps saturating bubble and flush performance counters.

---
 rtl/rv32i_types.sv | 56 +++++
 rtl/id_ex_stage_detect.sv | 37 +++
 rtl/id_ex_stage.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types.
// Contents:
//   rv32i_opcode        - base opcode encodings
//   rv32i_control_word  - decoded control word passed down the pipeline
//   BUBBLE_CTRL         - the all-zero control word; performs no action
//   uses_rs1/uses_rs2   - report whether an opcode actually reads rs1/rs2
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    rv32i_opcode opcode;
    logic [2:0]  aluop;
    logic [2:0]  cmpop;
    logic        alumux1_sel;
    logic [2:0]  alumux2_sel;
    logic [3:0]  regfilemux_sel;
    logic        marmux_sel;
    logic        cmpmux_sel;
    logic        load_regfile;
    logic        load_pc;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [2:0]  funct3;
    logic        funct7;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic [4:0]  rd_id;
  } rv32i_control_word;

  // All fields zero: no register write, no PC load, no memory access.
  localparam rv32i_control_word BUBBLE_CTRL = '0;

  // U-type and JAL have no rs1 field; the bits there belong to the immediate.
  function automatic logic uses_rs1(input rv32i_opcode op);
    return !((op == op_lui) || (op == op_auipc) || (op == op_jal));
  endfunction

  // Only R-type, branches and stores carry a real rs2.
  function automatic logic uses_rs2(input rv32i_opcode op);
    return (op == op_reg) || (op == op_br) || (op == op_store);
  endfunction

endpackage

// File: rtl/id_ex_stage_detect.sv
// load_use_detect: combinational load-use hazard comparator.
// Ports:
//   ex_valid, ex_mem_read, ex_rd_id   - instruction currently in EX
//   id_valid, id_opcode, id_rs1_id,
//   id_rs2_id                         - instruction currently in ID
//   load_use                          - ID needs a value the EX load has not produced yet
module load_use_detect
  import rv32i_types::*;
(
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd_id,
  input  logic        id_valid,
  input  rv32i_opcode id_opcode,
  input  logic [4:0]  id_rs1_id,
  input  logic [4:0]  id_rs2_id,
  output logic        load_use
);

  logic [1:0] src_used;
  logic [1:0] src_match;
  logic [4:0] src_id [2];

  assign src_used[0] = uses_rs1(id_opcode);
  assign src_used[1] = uses_rs2(id_opcode);
  assign src_id[0]   = id_rs1_id;
  assign src_id[1]   = id_rs2_id;

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_match[gi] = src_used[gi] && (src_id[gi] == ex_rd_id);
  end

  // x0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = ex_valid && ex_mem_read && (ex_rd_id != 5'd0) &&
                    id_valid && (|src_match);

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage RV32I core.
// Ports:
//   clk, rst (async, active low)
//   id_*            - decoded instruction and operands from ID
//   ex_ready        - low freezes the stage completely
//   ex_flush        - EX redirected the PC; kill the ID instruction
//   ex_*            - registered instruction handed to EX
//   id_hold         - combinational: hold PC and IF/ID this cycle
//   perf_bubbles    - saturating count of load-use bubbles
//   perf_flushes    - saturating count of flushed valid ID instructions
module id_ex_stage
  import rv32i_types::*;
#(
  parameter int CNT_WIDTH = 32
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  rv32i_control_word    id_ctrl,
  input  logic [31:0]          id_pc,
  input  logic [31:0]          id_rs1_out,
  input  logic [31:0]          id_rs2_out,
  input  logic [31:0]          id_imm,
  input  logic                 ex_ready,
  input  logic                 ex_flush,
  output logic                 ex_valid,
  output rv32i_control_word    ex_ctrl,
  output logic [31:0]          ex_pc,
  output logic [31:0]          ex_rs1_out,
  output logic [31:0]          ex_rs2_out,
  output logic [31:0]          ex_imm,
  output logic                 id_hold,
  output logic [CNT_WIDTH-1:0] perf_bubbles,
  output logic [CNT_WIDTH-1:0] perf_flushes
);

  logic                 load_use;
  logic                 ex_valid_reg, ex_valid_next;
  rv32i_control_word    ex_ctrl_reg, ex_ctrl_next;
  logic [31:0]          ex_pc_reg, ex_pc_next;
  logic [31:0]          ex_rs1_reg, ex_rs1_next;
  logic [31:0]          ex_rs2_reg, ex_rs2_next;
  logic [31:0]          ex_imm_reg, ex_imm_next;
  logic [CNT_WIDTH-1:0] bubbles_reg, bubbles_next;
  logic [CNT_WIDTH-1:0] flushes_reg, flushes_next;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  load_use_detect u_detect (
    .ex_valid    (ex_valid_reg),
    .ex_mem_read (ex_ctrl_reg.mem_read),
    .ex_rd_id    (ex_ctrl_reg.rd_id),
    .id_valid    (id_valid),
    .id_opcode   (id_ctrl.opcode),
    .id_rs1_id   (id_ctrl.rs1_id),
    .id_rs2_id   (id_ctrl.rs2_id),
    .load_use    (load_use)
  );

  // A flush redirects the frontend, so it must not also be held.
  assign id_hold = ~ex_ready | (load_use & ~ex_flush);

  always_comb begin
    ex_valid_next = ex_valid_reg;
    ex_ctrl_next  = ex_ctrl_reg;
    ex_pc_next    = ex_pc_reg;
    ex_rs1_next   = ex_rs1_reg;
    ex_rs2_next   = ex_rs2_reg;
    ex_imm_next   = ex_imm_reg;
    bubbles_next  = bubbles_reg;
    flushes_next  = flushes_reg;

    if (ex_ready) begin
      if (ex_flush || load_use) begin
        ex_valid_next = 1'b0;
        ex_ctrl_next  = BUBBLE_CTRL;
        ex_pc_next    = '0;
        ex_rs1_next   = '0;
        ex_rs2_next   = '0;
        ex_imm_next   = '0;
        if (ex_flush) begin
          if (id_valid) flushes_next = sat_inc(flushes_reg);
        end else begin
          bubbles_next = sat_inc(bubbles_reg);
        end
      end else begin
        ex_valid_next = id_valid;
        ex_ctrl_next  = id_ctrl;
        // An empty ID slot must never write state downstream.
        ex_ctrl_next.load_regfile = id_ctrl.load_regfile & id_valid;
        ex_ctrl_next.mem_read     = id_ctrl.mem_read & id_valid;
        ex_ctrl_next.mem_write    = id_ctrl.mem_write & id_valid;
        ex_pc_next    = id_pc;
        ex_rs1_next   = id_rs1_out;
        ex_rs2_next   = id_rs2_out;
        ex_imm_next   = id_imm;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_reg <= 1'b0;
      ex_ctrl_reg  <= BUBBLE_CTRL;
      ex_pc_reg    <= '0;
      ex_rs1_reg   <= '0;
      ex_rs2_reg   <= '0;
      ex_imm_reg   <= '0;
      bubbles_reg  <= '0;
      flushes_reg  <= '0;
    end else begin
      ex_valid_reg <= ex_valid_next;
      ex_ctrl_reg  <= ex_ctrl_next;
      ex_pc_reg    <= ex_pc_next;
      ex_rs1_reg   <= ex_rs1_next;
      ex_rs2_reg   <= ex_rs2_next;
      ex_imm_reg   <= ex_imm_next;
      bubbles_reg  <= bubbles_next;
      flushes_reg  <= flushes_next;
    end
  end

  assign ex_valid     = ex_valid_reg;
  assign ex_ctrl      = ex_ctrl_reg;
  assign ex_pc        = ex_pc_reg;
  assign ex_rs1_out   = ex_rs1_reg;
  assign ex_rs2_out   = ex_rs2_reg;
  assign ex_imm       = ex_imm_reg;
  assign perf_bubbles = bubbles_reg;
  assign perf_flushes = flushes_reg;

endmodule
